brick_collision: RTL and testbench
==================================

BRICK_COLLISION -- requirements
Module: brick_collision

Interface
REQ-001 Parameter BALL_R, default 10, ball radius in pixels.
REQ-002 Parameter GRID_TOP, default 64, first pixel row of the brick field.
REQ-003 Parameter BRICK_W_LOG2, default 7, brick width 128 px.
REQ-004 Parameter BRICK_H_LOG2, default 5, brick height 32 px.
REQ-005 Parameters ROWS, default 4, and COLS, default 8; the brick count is ROWS*COLS = 32.
REQ-006 pclk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 x_pos  in  12  ball centre x, pixel units.
REQ-009 y_pos  in  12  ball centre y, pixel units, from the vertical ball mover.
REQ-010 collision_det  out  1  registered, level-held hit flag, consumed by the vertical ball mover.
REQ-011 brick_map  out  32  live-brick bitmap; bit index = row*COLS + col; 1 = brick present.
REQ-012 bricks_left  out  6  count of set bits in brick_map.
REQ-013 score  out  16  number of bricks destroyed since reset.
REQ-014 all_cleared  out  1  high while bricks_left == 0.

Function
REQ-015 The block SHALL hold latched copies lx, ly of the last evaluated ball position.
REQ-016 FSM states: IDLE, CHK_TOP, CHK_BOT, HOLD.
REQ-017 IDLE: if (x_pos,y_pos) != (lx,ly), latch the inputs into lx/ly and go to CHK_TOP; otherwise stay in IDLE.
REQ-018 CHK_TOP tests point (lx, ly-BALL_R).
- Hit on a live brick: clear its bit, increment score, decrement bricks_left, go to HOLD.
- Otherwise: go to CHK_BOT.
REQ-019 CHK_BOT tests point (lx, ly+BALL_R).
- Hit on a live brick: clear its bit, update counters as in REQ-018, go to HOLD.
- Otherwise: go to IDLE.
REQ-020 A point (px,py) lies in the grid iff GRID_TOP <= py < GRID_TOP + ROWS<<BRICK_H_LOG2 and px < COLS<<BRICK_W_LOG2.
- row = (py-GRID_TOP) >> BRICK_H_LOG2
- col = px >> BRICK_W_LOG2
REQ-021 If ly < BALL_R, the top point is invalid: CHK_TOP SHALL report no hit and must not wrap.
- ly+BALL_R uses 13-bit arithmetic, so it cannot wrap.
REQ-022 At most one brick SHALL be destroyed per latched position; the top point has priority over the bottom point.
REQ-023 collision_det SHALL be 1 exactly while the FSM is in HOLD.
- It is registered: it rises the cycle after the hitting CHK state.
- It is held until the position changes, because the consumer samples it only at its own movement tick.
REQ-024 HOLD: when (x_pos,y_pos) != (lx,ly), latch the inputs and go to CHK_TOP.
- collision_det deasserts on that same edge.
REQ-025 Input changes while in CHK_TOP/CHK_BOT SHALL be ignored.
- Evaluation uses lx/ly.
- The change is picked up by the IDLE compare afterwards.
REQ-026 A cleared brick SHALL never re-set except by reset.
- Hit points on dead bricks count as a miss.
REQ-027 Latency from input change to collision_det high: 3 cycles on a top hit, 4 cycles on a bottom hit.
REQ-028 All outputs are registered; bricks_left and score SHALL NOT underflow or wrap (score saturates at 16'hFFFF).
REQ-029 all_cleared SHALL be registered and consistent with bricks_left on every cycle.

Reset
REQ-030 On reset (synchronous, priority over all other activity, including mid-CHK or HOLD), the block SHALL set:
- state = IDLE
- brick_map = 32'hFFFF_FFFF
- bricks_left = 32
- score = 0
- collision_det = 0
- all_cleared = 0
- lx = 0, ly = 0

Verification
REQ-031 Reset, then x=300, y=200 (bottom point 210): cycle 2 CHK_TOP (top point 190) hits row 3, col 2 -> bit 26 clears, score=1, bricks_left=31, collision_det=1 from cycle 3 and held while the input is unchanged.
REQ-032 From REQ-031, hold the input for 1000 cycles, then step to y=199: collision_det drops on the change edge; the top point (189) lands on dead bit 26, then the bottom point (209) is out of the grid -> no hit, score stays 1.
REQ-033 x=50, y=5 (top point invalid, bottom point 15 outside the grid) -> no hit, no wrap, brick_map unchanged.
REQ-034 x=1100, y=100 (px beyond 1023) -> no hit on any brick.
REQ-035 Sweep positions to hit all 32 bricks -> bricks_left=0, all_cleared=1, score=32; any further position -> no collision.
REQ-036 Assert reset while in HOLD after 5 hits -> the next cycle shows brick_map=FFFF_FFFF, score=0, bricks_left=32, collision_det=0.

Source files
------------

// File: rtl/brick_collision.sv
// brick_collision
//   Tracks a ROWS x COLS brick field and checks the ball against it each
//   time the ball position changes. Two points are tested, in order: the
//   point above the ball centre and then the point below it. At most one
//   brick is destroyed for each latched position.
//
// Ports
//   pclk          in   clock; all state changes on the rising edge
//   reset         in   synchronous, active-high reset
//   x_pos, y_pos  in   ball centre position in pixels
//   collision_det out  high while the FSM is in HOLD (a brick was just hit)
//   brick_map     out  live-brick bitmap, bit = row*COLS + col
//   bricks_left   out  number of set bits in brick_map
//   score         out  bricks destroyed since reset (saturating)
//   all_cleared   out  high while bricks_left == 0
module brick_collision #(
    parameter int BALL_R       = 10,
    parameter int GRID_TOP     = 64,
    parameter int BRICK_W_LOG2 = 7,
    parameter int BRICK_H_LOG2 = 5,
    parameter int ROWS         = 4,
    parameter int COLS         = 8
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic [11:0]            x_pos,
    input  logic [11:0]            y_pos,
    output logic                   collision_det,
    output logic [ROWS*COLS-1:0]   brick_map,
    output logic [5:0]             bricks_left,
    output logic [15:0]            score,
    output logic                   all_cleared
);
    localparam int NB   = ROWS * COLS;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;

    // 13-bit point arithmetic so ly + BALL_R can never wrap.
    localparam logic [12:0] R13   = 13'(BALL_R);
    localparam logic [12:0] TOP13 = 13'(GRID_TOP);
    localparam logic [12:0] BOT13 = 13'(GRID_TOP + (ROWS << BRICK_H_LOG2));
    localparam logic [12:0] GW13  = 13'(COLS << BRICK_W_LOG2);

    typedef enum logic [1:0] {IDLE, CHK_TOP, CHK_BOT, HOLD} state_t;

    state_t            state;
    logic [11:0]       lx, ly;

    logic [12:0]       py, rel, row, col;
    logic              is_top, in_grid, hit, moved;
    logic [IDXW-1:0]   idx;

    always_comb begin
        is_top  = (state == CHK_TOP);
        moved   = (x_pos != lx) || (y_pos != ly);
        py      = is_top ? ({1'b0, ly} - R13) : ({1'b0, ly} + R13);
        // A top point above pixel row 0 is simply not tested.
        in_grid = (py >= TOP13) && (py < BOT13) && ({1'b0, lx} < GW13)
                  && !(is_top && ({1'b0, ly} < R13));
        rel     = py - TOP13;
        row     = rel >> BRICK_H_LOG2;
        col     = {1'b0, lx} >> BRICK_W_LOG2;
        idx     = IDXW'(IDXW'(row) * IDXW'(COLS) + IDXW'(col));
        hit     = ((state == CHK_TOP) || (state == CHK_BOT))
                  && in_grid && brick_map[idx];
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state         <= IDLE;
            brick_map     <= '1;
            bricks_left   <= 6'(NB);
            score         <= '0;
            collision_det <= 1'b0;
            all_cleared   <= 1'b0;
            lx            <= '0;
            ly            <= '0;
        end else begin
            if (hit) begin
                brick_map[idx] <= 1'b0;
                if (score != 16'hFFFF)
                    score <= score + 16'd1;
                if (bricks_left != 6'd0) begin
                    bricks_left <= bricks_left - 6'd1;
                    all_cleared <= (bricks_left == 6'd1);
                end
            end
            case (state)
                IDLE, HOLD: begin
                    if (moved) begin
                        lx            <= x_pos;
                        ly            <= y_pos;
                        state         <= CHK_TOP;
                        collision_det <= 1'b0;
                    end
                end
                CHK_TOP: begin
                    if (hit) begin
                        state         <= HOLD;
                        collision_det <= 1'b1;
                    end else begin
                        state <= CHK_BOT;
                    end
                end
                CHK_BOT: begin
                    if (hit) begin
                        state         <= HOLD;
                        collision_det <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brick_collision.sv
module tb_brick_collision;
    logic        pclk = 1'b0;
    logic        reset;
    logic [11:0] x_pos, y_pos;
    logic        collision_det;
    logic [31:0] brick_map;
    logic [5:0]  bricks_left;
    logic [15:0] score;
    logic        all_cleared;

    int total = 0;
    int bad   = 0;

    // reference model: brick field as an array of alive flags
    bit alive [32];
    int m_score, m_left, m_lx, m_ly;

    brick_collision dut (
        .pclk(pclk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .collision_det(collision_det), .brick_map(brick_map),
        .bricks_left(bricks_left), .score(score), .all_cleared(all_cleared)
    );

    always #5 pclk = ~pclk;

    function automatic int brick_at(int px, int py);
        if (px < 0 || py < 64 || py >= 64 + 4 * 32 || px >= 8 * 128) return -1;
        return ((py - 64) / 32) * 8 + px / 128;
    endfunction

    function automatic logic [31:0] model_map();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = alive[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) alive[i] = 1'b1;
        m_score = 0; m_left = 32; m_lx = 0; m_ly = 0;
    endtask

    // Returns the brick destroyed (or -1) and the number of edges after the
    // input change at which collision_det is first seen high.
    task automatic model_eval(input int x, input int y, output int hit, output int lat);
        int t, b;
        hit = -1; lat = 0;
        t = (y >= 10) ? brick_at(x, y - 10) : -1;
        b = brick_at(x, y + 10);
        if (t >= 0 && alive[t]) begin hit = t; lat = 2; end
        else if (b >= 0 && alive[b]) begin hit = b; lat = 3; end
        if (hit >= 0) begin
            alive[hit] = 1'b0; m_left--;
            if (m_score < 65535) m_score++;
        end
        m_lx = x; m_ly = y;
    endtask

    task automatic check_regs(input string name);
        total++;
        if (brick_map !== model_map()) begin
            bad++; $display("FAIL %s brick_map got=%h want=%h", name, brick_map, model_map());
        end
        total++;
        if (score !== 16'(m_score)) begin
            bad++; $display("FAIL %s score got=%0d want=%0d", name, score, m_score);
        end
        total++;
        if (bricks_left !== 6'(m_left)) begin
            bad++; $display("FAIL %s bricks_left got=%0d want=%0d", name, bricks_left, m_left);
        end
        total++;
        if (all_cleared !== (m_left == 0)) begin
            bad++; $display("FAIL %s all_cleared got=%b want=%b", name, all_cleared, m_left == 0);
        end
    endtask

    // Drive a new position on a negedge and check collision_det after each of
    // the next four rising edges, then the counters.
    task automatic move_to(input int x, input int y, input string name);
        int hit, lat;
        logic want;
        if (x == m_lx && y == m_ly) return;
        @(negedge pclk);
        x_pos = 12'(x); y_pos = 12'(y);
        model_eval(x, y, hit, lat);
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            want = (hit >= 0) && (k >= lat);
            total++;
            if (collision_det !== want) begin
                bad++;
                $display("FAIL %s det@%0d (%0d,%0d) got=%b want=%b", name, k, x, y, collision_det, want);
            end
        end
        check_regs(name);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset = 1'b1; x_pos = '0; y_pos = '0;
        @(negedge pclk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (collision_det !== 1'b0) begin
            bad++; $display("FAIL reset det got=%b want=0", collision_det);
        end
        check_regs("reset");
    endtask

    task automatic test_directed();
        move_to(300, 200, "top_hit");          // top point 190 -> bit 26
        total++;
        if (brick_map[26] !== 1'b0) begin
            bad++; $display("FAIL bit26 got=%b want=0", brick_map[26]);
        end
        for (int c = 0; c < 1000; c++) begin
            @(negedge pclk);
            if (c % 100 == 99) begin
                total++;
                if (collision_det !== 1'b1) begin
                    bad++; $display("FAIL hold det cyc%0d got=%b want=1", c, collision_det);
                end
            end
        end
        move_to(300, 199, "dead_brick");       // 189 dead, 209 out of grid
        move_to(50, 5, "top_invalid");
        move_to(1100, 100, "x_out");
        move_to(200, 40, "bottom_hit");        // top 30 out, bottom 50 out -> miss
        move_to(200, 60, "bottom_hit2");       // top 50 out, bottom 70 -> bit 1
    endtask

    task automatic test_mid_change();
        int hit, lat;
        @(negedge pclk);
        x_pos = 12'(700); y_pos = 12'(150);
        model_eval(700, 150, hit, lat);
        @(negedge pclk);                       // DUT now in CHK_TOP
        x_pos = 12'(900); y_pos = 12'(120);
        model_eval(900, 120, hit, lat);
        repeat (10) @(negedge pclk);
        total++;
        if (collision_det !== (hit >= 0)) begin
            bad++; $display("FAIL mid_change det got=%b want=%b", collision_det, hit >= 0);
        end
        check_regs("mid_change");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            move_to(int'($urandom_range(0, 1200)), int'($urandom_range(0, 260)), "random");
    endtask

    task automatic test_clear_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                move_to(c * 128 + 64, 64 + r * 32 + 16 + 10, "sweep");
        total++;
        if (all_cleared !== 1'b1 || bricks_left !== 6'd0) begin
            bad++; $display("FAIL cleared got=%b/%0d want=1/0", all_cleared, bricks_left);
        end
        move_to(500, 130, "after_clear");
        move_to(100, 90, "after_clear2");
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        for (int i = 0; i < 5; i++) move_to(i * 128 + 10, 64 + 16 + 10, "pre_reset");
        total++;
        if (collision_det !== 1'b1) begin
            bad++; $display("FAIL pre_reset hold got=%b want=1", collision_det);
        end
        @(negedge pclk);
        reset = 1'b1; x_pos = '0; y_pos = '0;
        @(negedge pclk);
        model_reset();
        total++;
        if (collision_det !== 1'b0) begin
            bad++; $display("FAIL reset_hold det got=%b want=0", collision_det);
        end
        check_regs("reset_hold");
        reset = 1'b0;
        move_to(300, 200, "post_reset");
    endtask

    initial begin
        reset = 1'b1; x_pos = '0; y_pos = '0;
        model_reset();
        repeat (2) @(negedge pclk);
        test_reset();
        test_directed();
        test_mid_change();
        test_random();
        test_clear_all();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
